display_scan_driver: RTL and testbench
======================================

Name: display_scan_driver

Overview:
Time-multiplexed driver for the 4-digit seven-segment display on the multiplier board. Consumes the segment bytes K and enable bits eT from the four digit-logic blocks (1s, 10s, 100s, 1000s) and runs the refresh counter they gate. It drives the shared active-low cathode bus and the per-digit active-low anodes, with anti-ghost blanking between digits. Inputs are snapshotted per frame so the display never tears mid-scan.

Parameters:
DIV, 16'd50000, ON-time per digit in CLK cycles (legal range 2..65535).
BLANK_CYC, 16'd500, all-anodes-off gap before each digit in CLK cycles (legal range 1..DIV-1).

Ports:
CLK  in  1  system clock; all logic is on its rising edge.
RST  in  1  synchronous, active-high reset.
K0  in  8  1s digit segments {a,b,c,d,e,f,g,dp}; 1 = segment lit.
K1  in  8  10s digit segments; same format as K0.
K2  in  8  100s digit segments; same format as K0.
K3  in  8  1000s digit segments; same format as K0.
eT  in  4  per-digit counter enable; eT[i]=1 means digit i takes part in the scan.
AN  out  4  anode selects, active-low; AN[i] drives digit i.
SEG  out  8  cathode bus, active-low; SEG = ~K of the selected digit.
FRAME  out  1  one-cycle pulse when a scan frame completes.

Behaviour:
- Clock and reset: one clock (CLK); reset RST is synchronous and active-high.
- All outputs are registered.
- Reset values: state=IDLE, AN=4'b1111, SEG=8'hFF, FRAME=0, ptr=0, cnt=0, snapshot K and eT = 0.
- RST has priority over every event. Asserting it mid-operation returns all outputs to their reset values on the next edge.
- States are IDLE, BLANK and ON.
- IDLE:
  - AN=1111, SEG=FF.
  - When eT!=0 at an edge: snapshot K0..K3 and eT, set ptr to the lowest set bit of the snapshot eT, clear cnt, go to BLANK.
- BLANK:
  - AN=1111, SEG=FF.
  - cnt counts from 0. After BLANK_CYC cycles in BLANK: clear cnt and go to ON.
- ON:
  - AN[ptr]=0, all other AN bits 1. SEG = ~snapK[ptr].
  - Stays in ON for DIV cycles.
  - On exit, ptr advances to the next set bit of the snapshot eT above ptr, then state goes to BLANK.
  - If no set bit exists above ptr, the frame ends:
    - FRAME=1 for exactly the following cycle.
    - Re-snapshot K0..K3 and eT at that edge.
    - If the new eT==0, go to IDLE. Otherwise set ptr to its lowest set bit and go to BLANK.
- Scan order is ascending digit index 0->3.
- Digits whose snapshot eT bit is 0 are skipped entirely and consume no time.
- Single enabled digit: each frame is BLANK then ON on that digit, and FRAME pulses every BLANK_CYC+DIV cycles.
- Frame period is N*(BLANK_CYC+DIV) cycles, where N = popcount(snapshot eT).
- Latency: if eT goes nonzero and is sampled at edge n, BLANK starts at cycle n+1 and the first anode goes low at cycle n+1+BLANK_CYC.
- Changes to K or eT during a frame have no effect until the next frame boundary. This includes eT dropping to 0: the current frame completes first.
- cnt is 16 bits and resets to 0 on every state change. It never wraps, because DIV is at most 65535.
- At most one AN bit is low in any cycle. SEG=FF whenever AN=1111.

Test Plan:
1. Reset: DIV=4, BLANK_CYC=1, RST high for 2 cycles -> AN=1111, SEG=FF, FRAME=0; state stays IDLE while eT=0.
2. Full scan: eT=1111, K0=01, K1=02, K2=04, K3=08 -> per frame AN follows 1111(1 cycle), 1110(4), 1111(1), 1101(4), 1111(1), 1011(4), 1111(1), 0111(4). SEG=FE, FD, FB, F7 during the respective ON windows. FRAME pulses once every 20 cycles, in the cycle after the 0111 window.
3. Sparse scan: eT=0101 -> only AN=1110 and 1011 are asserted, each for 4 cycles; FRAME period is 10 cycles.
4. Snapshot: change K1 from 02 to 80 while digit 0 is ON -> the current frame still shows SEG=FD on digit 1; the next frame shows SEG=7F.
5. Disable mid-frame: eT set to 0000 during digit 1 ON -> digits 2 and 3 still scan, FRAME pulses, then AN=1111 and SEG=FF are held (IDLE).
6. Reset mid-ON: RST=1 for one cycle while AN=1101 -> next cycle AN=1111, SEG=FF, FRAME=0. Scan restarts from digit 0 after RST deasserts, provided eT!=0.

Source files
------------

// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with anti-ghost blanking.
// Segment/enable inputs are snapshotted at each frame boundary so a frame never tears.
module display_scan_driver #(
  parameter logic [15:0] DIV       = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] K0,
  input  logic [7:0] K1,
  input  logic [7:0] K2,
  input  logic [7:0] K3,
  input  logic [3:0] eT,
  output logic [3:0] AN,
  output logic [7:0] SEG,
  output logic       FRAME
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBlank = 2'd1;
  localparam logic [1:0] StOn    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      snap_et_q, snap_et_d;
  logic [3:0][7:0] snap_k_q, snap_k_d;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d;
  logic            frame_q, frame_d;
  logic [3:0]      rest;
  logic [3:0][7:0] k_in;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign k_in = {K3, K2, K1, K0};
  // Enabled digits strictly above the current pointer.
  assign rest = snap_et_q & (4'b1110 << ptr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    snap_et_d = snap_et_q;
    snap_k_d  = snap_k_q;
    frame_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (eT != 4'd0) begin
          snap_k_d  = k_in;
          snap_et_d = eT;
          ptr_d     = lowest_bit(eT);
          cnt_d     = 16'd0;
          state_d   = StBlank;
        end
      end
      StBlank: begin
        if (cnt_q == BLANK_CYC - 16'd1) begin
          cnt_d   = 16'd0;
          state_d = StOn;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StOn: begin
        if (cnt_q == DIV - 16'd1) begin
          cnt_d = 16'd0;
          if (rest != 4'd0) begin
            ptr_d   = lowest_bit(rest);
            state_d = StBlank;
          end else begin
            frame_d   = 1'b1;
            snap_k_d  = k_in;
            snap_et_d = eT;
            if (eT == 4'd0) begin
              ptr_d   = 2'd0;
              state_d = StIdle;
            end else begin
              ptr_d   = lowest_bit(eT);
              state_d = StBlank;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = StIdle;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (state_d == StOn) begin
      an_d[ptr_d] = 1'b0;
      seg_d       = ~snap_k_d[ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      ptr_q     <= 2'd0;
      snap_et_q <= 4'd0;
      snap_k_q  <= '0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      snap_et_q <= snap_et_d;
      snap_k_q  <= snap_k_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      frame_q   <= frame_d;
    end
  end

  assign AN    = an_q;
  assign SEG   = seg_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver: expected ON windows and FRAME pulses are queued,
// a negedge monitor reconstructs them from AN/SEG/FRAME and compares.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] k0, k1, k2, k3;
  logic [3:0] et;
  logic [3:0] an;
  logic [7:0] seg;
  logic       frame;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_frame;
    logic [3:0] an;
    logic [7:0] seg;
    int         len;
  } ev_t;

  ev_t exp_q[$];

  bit         mon_en   = 1'b0;
  logic [3:0] prev_an  = 4'hF;
  logic [7:0] prev_seg = 8'hFF;
  int         run_len  = 0;
  int         gap_cnt  = 0;

  display_scan_driver #(
    .DIV      (16'd4),
    .BLANK_CYC(16'd1)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .K0   (k0),
    .K1   (k1),
    .K2   (k2),
    .K3   (k3),
    .eT   (et),
    .AN   (an),
    .SEG  (seg),
    .FRAME(frame)
  );

  always #5 clk = ~clk;

  task automatic push_ev(input bit f, input logic [3:0] a, input logic [7:0] s, input int l);
    ev_t e;
    e.is_frame = f;
    e.an       = a;
    e.seg      = s;
    e.len      = l;
    exp_q.push_back(e);
  endtask

  task automatic push_full(input logic [7:0] seg1, input int gap);
    push_ev(1'b0, 4'b1110, 8'hFE, 4);
    push_ev(1'b0, 4'b1101, seg1, 4);
    push_ev(1'b0, 4'b1011, 8'hFB, 4);
    push_ev(1'b0, 4'b0111, 8'hF7, 4);
    push_ev(1'b1, 4'hF, 8'hFF, gap);
  endtask

  task automatic emit(input bit f, input logic [3:0] a, input logic [7:0] s, input int l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got frame=%0b an=%b seg=%h len=%0d, required none",
               f, a, s, l);
    end else begin
      e = exp_q.pop_front();
      if (e.is_frame != f || e.an != a || e.seg != s || (e.len != 0 && e.len != l)) begin
        failures++;
        $display("FAIL event: got frame=%0b an=%b seg=%h len=%0d, required frame=%0b an=%b seg=%h len=%0d",
                 f, a, s, l, e.is_frame, e.an, e.seg, e.len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      gap_cnt++;
      checks++;
      if ((an == 4'hF && seg != 8'hFF) || $countones(~an) > 1) begin
        failures++;
        $display("FAIL invariant: got an=%b seg=%h, required one-cold an and seg=ff when blank",
                 an, seg);
      end
      if (an != prev_an) begin
        if (prev_an != 4'hF) emit(1'b0, prev_an, prev_seg, run_len);
        prev_an  = an;
        prev_seg = seg;
        run_len  = 1;
      end else begin
        run_len++;
      end
      if (frame) begin
        emit(1'b1, 4'hF, 8'hFF, gap_cnt);
        gap_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_an"}, {4'h0, an}, 8'h0F);
    chk({name, "_seg"}, seg, 8'hFF);
    chk({name, "_frame"}, {7'd0, frame}, 8'h00);
  endtask

  task automatic wait_frame(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: got no FRAME pulse within 200 cycles, required one", name);
    end
  endtask

  task automatic wait_an(input string name, input logic [3:0] val);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (an == val) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: got no AN=%b within 200 cycles, required it", name, val);
    end
  endtask

  initial begin
    rst = 1'b1;
    et  = 4'd0;
    k0  = 8'h00;
    k1  = 8'h00;
    k2  = 8'h00;
    k3  = 8'h00;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle("idle_et0");
    end
    mon_en = 1'b1;

    // Frames A..E: full, full, sparse, full, full with K1 changed mid-frame D.
    push_full(8'hFD, 0);
    push_full(8'hFD, 20);
    push_ev(1'b0, 4'b1110, 8'hFE, 4);
    push_ev(1'b0, 4'b1011, 8'hFB, 4);
    push_ev(1'b1, 4'hF, 8'hFF, 10);
    push_full(8'hFD, 20);
    push_full(8'h7F, 20);

    k0 = 8'h01;
    k1 = 8'h02;
    k2 = 8'h04;
    k3 = 8'h08;
    et = 4'b1111;
    wait_frame("frame_a");
    et = 4'b0101;
    wait_frame("frame_b");
    et = 4'b1111;
    wait_frame("frame_c");
    wait_an("frame_d_digit0", 4'b1110);
    k1 = 8'h80;
    wait_frame("frame_d");
    wait_an("frame_e_digit1", 4'b1101);
    et = 4'b0000;
    wait_frame("frame_e");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_idle("idle_after_disable");
    end

    // Reset while digit 1 is ON, then a full restart from digit 0.
    push_ev(1'b0, 4'b1110, 8'hFE, 4);
    push_ev(1'b0, 4'b1101, 8'h7F, 1);
    push_full(8'h7F, 0);
    et = 4'b1111;
    wait_an("frame_f_digit1", 4'b1101);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("reset_mid_on");
    rst = 1'b0;
    @(negedge clk);
    et = 4'b0000;
    wait_frame("frame_g");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_idle("idle_end");
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
